// File: rtl/fp_cmp_pkg.sv
// Shared types for the arbitrated floating-point compare unit: opcodes, canonical NaNs,
// the stage-1 payload and the raw flag bundle produced by FP_Compare.
package fp_cmp_pkg;

    typedef enum logic [2:0] {
        FEQ  = 3'd0,
        FLT  = 3'd1,
        FLE  = 3'd2,
        FMIN = 3'd3,
        FMAX = 3'd4
    } fp_cmp_op_e;

    localparam logic [63:0] CANON_NAN_DP = 64'h7FF8_0000_0000_0000;
    localparam logic [63:0] CANON_NAN_SP = 64'h0000_0000_7FC0_0000;

    // Widest requester ID the payload can carry; the top narrows it to ID_W.
    localparam int ID_MAX_W = 8;

    typedef struct packed {
        fp_cmp_op_e          op;
        logic                dp;
        logic [63:0]         a;
        logic [63:0]         b;
        logic [ID_MAX_W-1:0] id;
    } s1_payload_t;

    typedef struct packed {
        logic eq;
        logic lt;
        logic gt;
        logic unordered;
        logic a_nan;
        logic b_nan;
        logic a_snan;
        logic b_snan;
        logic a_sgn;
    } cmp_flags_t;

endpackage

// File: rtl/FP_Compare.sv
// Purely combinational IEEE-754 compare of two SP or DP operands, producing ordered
// relation flags plus NaN classification; zero latency, no handshake.
module FP_Compare
    import fp_cmp_pkg::*;
(
    input  logic [63:0] a_i,
    input  logic [63:0] b_i,
    input  logic        dp_i,
    output cmp_flags_t  flags_o
);

    logic        sgn_a, sgn_b;
    logic        nan_a, nan_b;
    logic        qbit_a, qbit_b;
    logic [62:0] mag_a, mag_b;
    logic        zero_both, mag_eq, mag_lt, unord;

    always_comb begin
        if (dp_i) begin
            sgn_a  = a_i[63];
            sgn_b  = b_i[63];
            mag_a  = a_i[62:0];
            mag_b  = b_i[62:0];
            nan_a  = (&a_i[62:52]) & (|a_i[51:0]);
            nan_b  = (&b_i[62:52]) & (|b_i[51:0]);
            qbit_a = a_i[51];
            qbit_b = b_i[51];
        end else begin
            sgn_a  = a_i[31];
            sgn_b  = b_i[31];
            mag_a  = {32'd0, a_i[30:0]};
            mag_b  = {32'd0, b_i[30:0]};
            nan_a  = (&a_i[30:23]) & (|a_i[22:0]);
            nan_b  = (&b_i[30:23]) & (|b_i[22:0]);
            qbit_a = a_i[22];
            qbit_b = b_i[22];
        end
    end

    // Sign-magnitude ordering: exponent-then-mantissa compares as an unsigned integer.
    always_comb begin
        unord     = nan_a | nan_b;
        zero_both = (mag_a == 63'd0) && (mag_b == 63'd0);
        mag_eq    = (mag_a == mag_b);
        mag_lt    = (mag_a < mag_b);

        flags_o           = '0;
        flags_o.unordered = unord;
        flags_o.a_nan     = nan_a;
        flags_o.b_nan     = nan_b;
        flags_o.a_snan    = nan_a & ~qbit_a;
        flags_o.b_snan    = nan_b & ~qbit_b;
        flags_o.a_sgn     = sgn_a;

        if (!unord) begin
            if (zero_both || ((sgn_a == sgn_b) && mag_eq)) begin
                flags_o.eq = 1'b1;
            end else if (sgn_a != sgn_b) begin
                flags_o.lt = sgn_a;
            end else begin
                flags_o.lt = sgn_a ? ~mag_lt : mag_lt;
            end
            flags_o.gt = ~flags_o.eq & ~flags_o.lt;
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after the pointer, combinationally;
// the pointer moves past the winner only when the grant is actually taken (adv_i).
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req_i,
    input  logic          adv_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] gnt_idx_o,
    output logic          any_o
);

    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] cand;
    int            slot;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        any_o     = 1'b0;
        slot      = 0;
        cand      = '0;
        for (int i = 0; i < N; i++) begin
            slot = int'(ptr_q) + i;
            if (slot >= N) slot = slot - N;
            cand = IW'(slot);
            if (!any_o && req_i[cand]) begin
                any_o       = 1'b1;
                gnt_o[cand] = 1'b1;
                gnt_idx_o   = cand;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (adv_i) begin
            ptr_d = (gnt_idx_o == IW'(N - 1)) ? '0 : gnt_idx_o + IW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/fp_compare_arbiter.sv
// NUM_REQ requesters share one FP_Compare; accept-to-rsp_valid latency is 2 edges.
// Full backpressure: a stalled response holds S2, then S1, then drops every req_ready.
module fp_compare_arbiter
    import fp_cmp_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*3-1:0]  req_op,
    input  logic [NUM_REQ-1:0]    req_dp,
    input  logic [NUM_REQ*64-1:0] req_a,
    input  logic [NUM_REQ*64-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [63:0]           rsp_result,
    output logic                  rsp_invalid
);

    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_idx;
    logic               gnt_any;
    logic               s1_free, s2_load, accept;

    s1_payload_t s1_in, s1_q, s1_d;
    logic        s1_valid_q, s1_valid_d;

    logic            rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0] rsp_id_q, rsp_id_d;
    logic [63:0]     rsp_result_q, rsp_result_d;
    logic            rsp_invalid_q, rsp_invalid_d;

    cmp_flags_t  flags;
    logic [63:0] op_a, op_b, canon, sel_res;
    logic        sel_inv, snan_any;

    assign s2_load   = s1_valid_q & (~rsp_valid_q | rsp_ready);
    assign s1_free   = ~s1_valid_q | s2_load;
    assign accept    = gnt_any & s1_free;
    assign req_ready = gnt & {NUM_REQ{s1_free}};

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (ID_W)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (req_valid),
        .adv_i     (accept),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx),
        .any_o     (gnt_any)
    );

    always_comb begin
        s1_in    = '0;
        s1_in.id = ID_MAX_W'(gnt_idx);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                s1_in.op = fp_cmp_op_e'(req_op[i*3 +: 3]);
                s1_in.dp = req_dp[i];
                s1_in.a  = req_a[i*64 +: 64];
                s1_in.b  = req_b[i*64 +: 64];
            end
        end
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_d       = s1_q;
        if (s1_free) begin
            s1_valid_d = accept;
            if (accept) s1_d = s1_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_q       <= s1_d;
        end
    end

    FP_Compare u_cmp (
        .a_i     (s1_q.a),
        .b_i     (s1_q.b),
        .dp_i    (s1_q.dp),
        .flags_o (flags)
    );

    always_comb begin
        sel_res  = '0;
        sel_inv  = 1'b0;
        op_a     = s1_q.dp ? s1_q.a : {32'd0, s1_q.a[31:0]};
        op_b     = s1_q.dp ? s1_q.b : {32'd0, s1_q.b[31:0]};
        canon    = s1_q.dp ? CANON_NAN_DP : CANON_NAN_SP;
        snan_any = flags.a_snan | flags.b_snan;
        case (s1_q.op)
            FEQ: begin
                sel_res = {63'd0, flags.eq};
                sel_inv = snan_any;
            end
            FLT: begin
                sel_res = {63'd0, flags.lt};
                sel_inv = flags.unordered;
            end
            FLE: begin
                sel_res = {63'd0, flags.lt | flags.eq};
                sel_inv = flags.unordered;
            end
            FMIN, FMAX: begin
                sel_inv = snan_any;
                if (flags.a_nan && flags.b_nan) begin
                    sel_res = canon;
                end else if (flags.a_nan) begin
                    sel_res = op_b;
                end else if (flags.b_nan) begin
                    sel_res = op_a;
                end else if (flags.eq) begin
                    // Equal magnitudes (incl. +0/-0): min takes the negative, max the positive.
                    sel_res = ((s1_q.op == FMIN) == flags.a_sgn) ? op_a : op_b;
                end else if (s1_q.op == FMIN) begin
                    sel_res = flags.lt ? op_a : op_b;
                end else begin
                    sel_res = flags.gt ? op_a : op_b;
                end
            end
            default: begin
                sel_res = '0;
                sel_inv = 1'b0;
            end
        endcase
    end

    always_comb begin
        rsp_valid_d   = rsp_valid_q;
        rsp_id_d      = rsp_id_q;
        rsp_result_d  = rsp_result_q;
        rsp_invalid_d = rsp_invalid_q;
        if (s2_load) begin
            rsp_valid_d   = 1'b1;
            rsp_id_d      = s1_q.id[ID_W-1:0];
            rsp_result_d  = sel_res;
            rsp_invalid_d = sel_inv;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q   <= 1'b0;
            rsp_id_q      <= '0;
            rsp_result_q  <= '0;
            rsp_invalid_q <= 1'b0;
        end else begin
            rsp_valid_q   <= rsp_valid_d;
            rsp_id_q      <= rsp_id_d;
            rsp_result_q  <= rsp_result_d;
            rsp_invalid_q <= rsp_invalid_d;
        end
    end

    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_result  = rsp_result_q;
    assign rsp_invalid = rsp_invalid_q;

endmodule

// File: tb/tb_fp_compare_arbiter.sv
// Directed bench for fp_compare_arbiter: handshake, arbitration order and compare semantics.
module tb_fp_compare_arbiter;

    localparam int N  = 4;
    localparam int IW = 2;

    localparam logic [2:0] C_FEQ  = 3'd0;
    localparam logic [2:0] C_FLT  = 3'd1;
    localparam logic [2:0] C_FLE  = 3'd2;
    localparam logic [2:0] C_FMIN = 3'd3;
    localparam logic [2:0] C_FMAX = 3'd4;
    localparam logic [2:0] C_ILL  = 3'd5;

    localparam logic [63:0] D_ONE   = 64'h3FF0_0000_0000_0000;
    localparam logic [63:0] D_TWO   = 64'h4000_0000_0000_0000;
    localparam logic [63:0] D_THREE = 64'h4008_0000_0000_0000;
    localparam logic [63:0] D_QNAN  = 64'h7FF8_0000_0000_0000;
    localparam logic [63:0] D_SNAN  = 64'h7FF0_0000_0000_0001;
    localparam logic [63:0] D_NZERO = 64'h8000_0000_0000_0000;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_ready;
    logic [N*3-1:0]    req_op = '0;
    logic [N-1:0]      req_dp = '0;
    logic [N*64-1:0]   req_a = '0;
    logic [N*64-1:0]   req_b = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [IW-1:0]     rsp_id;
    logic [63:0]       rsp_result;
    logic              rsp_invalid;

    int pass_cnt = 0;
    int total    = 0;

    always #5 clk = ~clk;

    fp_compare_arbiter #(.NUM_REQ(N), .ID_W(IW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_dp      (req_dp),
        .req_a       (req_a),
        .req_b       (req_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_result  (rsp_result),
        .rsp_invalid (rsp_invalid)
    );

    task automatic set_req(input int i, input logic [2:0] op, input logic dp,
                           input logic [63:0] a, input logic [63:0] b);
        req_op[i*3 +: 3]  = op;
        req_dp[i]         = dp;
        req_a[i*64 +: 64] = a;
        req_b[i*64 +: 64] = b;
        req_valid[i]      = 1'b1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Issues one op from requester 0 and returns the response fields.
    task automatic run_op(input logic [2:0] op, input logic dp, input logic [63:0] a,
                          input logic [63:0] b, output logic [63:0] res, output logic inv);
        int n;
        @(negedge clk);
        rsp_ready = 1'b1;
        set_req(0, op, dp, a, b);
        #1;
        n = 0;
        while (!req_ready[0] && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (rsp_valid !== 1'b1) $display("FAIL run_op_timeout: rsp_valid=%b required 1", rsp_valid);
        else pass_cnt++;
        res = rsp_result;
        inv = rsp_invalid;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b required 0", rsp_valid); else pass_cnt++;
        total++; if (rsp_id !== 2'd0) $display("FAIL reset_rsp_id: got %0d required 0", rsp_id); else pass_cnt++;
        total++; if (rsp_result !== 64'd0) $display("FAIL reset_rsp_result: got %h required 0", rsp_result); else pass_cnt++;
        total++; if (rsp_invalid !== 1'b0) $display("FAIL reset_rsp_invalid: got %b required 0", rsp_invalid); else pass_cnt++;
        total++; if (req_ready !== 4'b0000) $display("FAIL reset_req_ready: got %b required 0000", req_ready); else pass_cnt++;
        rst_n = 1'b1;
    endtask

    task automatic test_single_flt();
        @(negedge clk);
        rsp_ready = 1'b1;
        set_req(0, C_FLT, 1'b1, D_ONE, D_TWO);
        #1;
        total++; if (req_ready !== 4'b0001) $display("FAIL flt_req_ready: got %b required 0001", req_ready); else pass_cnt++;
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        @(negedge clk);
        total++; if (rsp_valid !== 1'b0) $display("FAIL flt_early_valid: got %b required 0", rsp_valid); else pass_cnt++;
        @(negedge clk);
        total++; if (rsp_valid !== 1'b1) $display("FAIL flt_valid: got %b required 1", rsp_valid); else pass_cnt++;
        total++; if (rsp_result !== 64'd1) $display("FAIL flt_result: got %h required 1", rsp_result); else pass_cnt++;
        total++; if (rsp_invalid !== 1'b0) $display("FAIL flt_invalid: got %b required 0", rsp_invalid); else pass_cnt++;
        total++; if (rsp_id !== 2'd0) $display("FAIL flt_id: got %0d required 0", rsp_id); else pass_cnt++;
    endtask

    task automatic test_nan();
        logic [63:0] r;
        logic        v;
        run_op(C_FEQ, 1'b1, D_SNAN, D_ONE, r, v);
        total++; if (r !== 64'd0) $display("FAIL feq_snan_result: got %h required 0", r); else pass_cnt++;
        total++; if (v !== 1'b1) $display("FAIL feq_snan_invalid: got %b required 1", v); else pass_cnt++;
        run_op(C_FLE, 1'b1, D_QNAN, D_ONE, r, v);
        total++; if (r !== 64'd0) $display("FAIL fle_qnan_result: got %h required 0", r); else pass_cnt++;
        total++; if (v !== 1'b1) $display("FAIL fle_qnan_invalid: got %b required 1", v); else pass_cnt++;
        run_op(C_FMIN, 1'b1, D_QNAN, D_TWO, r, v);
        total++; if (r !== D_TWO) $display("FAIL fmin_qnan_result: got %h required %h", r, D_TWO); else pass_cnt++;
        total++; if (v !== 1'b0) $display("FAIL fmin_qnan_invalid: got %b required 0", v); else pass_cnt++;
        run_op(C_FMAX, 1'b1, D_QNAN, D_QNAN, r, v);
        total++; if (r !== 64'h7FF8_0000_0000_0000) $display("FAIL fmax_2nan_result: got %h required 7ff8000000000000", r); else pass_cnt++;
        total++; if (v !== 1'b0) $display("FAIL fmax_2nan_invalid: got %b required 0", v); else pass_cnt++;
        run_op(C_FMAX, 1'b0, 64'h0000_0000_7FC0_0000, 64'h0000_0000_7FC0_0001, r, v);
        total++; if (r !== 64'h0000_0000_7FC0_0000) $display("FAIL fmax_sp_2nan_result: got %h required 000000007fc00000", r); else pass_cnt++;
    endtask

    task automatic test_signed_zero_sp();
        logic [63:0] r;
        logic        v;
        run_op(C_FMIN, 1'b1, 64'd0, D_NZERO, r, v);
        total++; if (r !== 64'h8000_0000_0000_0000) $display("FAIL fmin_zero_result: got %h required 8000000000000000", r); else pass_cnt++;
        run_op(C_FEQ, 1'b1, 64'd0, D_NZERO, r, v);
        total++; if (r !== 64'd1) $display("FAIL feq_zero_result: got %h required 1", r); else pass_cnt++;
        run_op(C_FMAX, 1'b0, 64'hDEAD_BEEF_3F80_0000, 64'h0000_0000_BF80_0000, r, v);
        total++; if (r !== 64'h0000_0000_3F80_0000) $display("FAIL fmax_sp_result: got %h required 000000003f800000", r); else pass_cnt++;
        run_op(C_ILL, 1'b1, D_ONE, D_SNAN, r, v);
        total++; if (r !== 64'd0) $display("FAIL illegal_result: got %h required 0", r); else pass_cnt++;
        total++; if (v !== 1'b0) $display("FAIL illegal_invalid: got %b required 0", v); else pass_cnt++;
    endtask

    task automatic test_round_robin();
        logic [N-1:0]  exp_rdy;
        logic [IW-1:0] exp_id;
        apply_reset();
        rsp_ready = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, C_FLT, 1'b1, D_ONE, D_TWO);
        for (int c = 0; c < 7; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            exp_rdy = N'(1 << (c % N));
            total++; if (req_ready !== exp_rdy) $display("FAIL rr_grant_c%0d: got %b required %b", c, req_ready, exp_rdy); else pass_cnt++;
            if (c >= 2) begin
                exp_id = IW'((c - 2) % N);
                total++;
                if (rsp_valid !== 1'b1 || rsp_id !== exp_id)
                    $display("FAIL rr_rsp_c%0d: valid=%b id=%0d required valid=1 id=%0d", c, rsp_valid, rsp_id, exp_id);
                else pass_cnt++;
            end
        end
        req_valid = '0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_backpressure();
        int acc;
        acc = 0;
        apply_reset();
        rsp_ready = 1'b0;
        set_req(0, C_FMIN, 1'b1, D_ONE, D_ONE);
        set_req(1, C_FMIN, 1'b1, D_TWO, D_TWO);
        set_req(2, C_FMIN, 1'b1, D_THREE, D_THREE);
        #1;
        total++; if (req_ready !== 4'b0001) $display("FAIL bp_c0_ready: got %b required 0001", req_ready); else pass_cnt++;
        acc += $countones(req_ready);
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        @(negedge clk);
        #1;
        total++; if (req_ready !== 4'b0010) $display("FAIL bp_c1_ready: got %b required 0010", req_ready); else pass_cnt++;
        acc += $countones(req_ready);
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
        for (int c = 2; c < 5; c++) begin
            @(negedge clk);
            #1;
            acc += $countones(req_ready);
            total++; if (req_ready !== 4'b0000) $display("FAIL bp_c%0d_ready: got %b required 0000", c, req_ready); else pass_cnt++;
            total++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_result !== D_ONE)
                $display("FAIL bp_stall_c%0d: valid=%b id=%0d res=%h required valid=1 id=0 res=%h", c, rsp_valid, rsp_id, rsp_result, D_ONE);
            else pass_cnt++;
        end
        total++; if (acc !== 2) $display("FAIL bp_accept_count: got %0d required 2", acc); else pass_cnt++;
        @(negedge clk);
        rsp_ready = 1'b1;
        #1;
        total++; if (req_ready !== 4'b0100) $display("FAIL bp_release_ready: got %b required 0100", req_ready); else pass_cnt++;
        @(posedge clk);
        #1 req_valid[2] = 1'b0;
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_result !== D_TWO)
            $display("FAIL bp_rsp1: valid=%b id=%0d res=%h required valid=1 id=1 res=%h", rsp_valid, rsp_id, rsp_result, D_TWO);
        else pass_cnt++;
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_result !== D_THREE)
            $display("FAIL bp_rsp2: valid=%b id=%0d res=%h required valid=1 id=2 res=%h", rsp_valid, rsp_id, rsp_result, D_THREE);
        else pass_cnt++;
        @(negedge clk);
        total++; if (rsp_valid !== 1'b0) $display("FAIL bp_no_dup: got %b required 0", rsp_valid); else pass_cnt++;
    endtask

    task automatic test_reset_midflight();
        apply_reset();
        rsp_ready = 1'b0;
        set_req(1, C_FLT, 1'b1, D_ONE, D_TWO);
        set_req(2, C_FLT, 1'b1, D_TWO, D_ONE);
        #1;
        total++; if (req_ready !== 4'b0010) $display("FAIL mid_c0_ready: got %b required 0010", req_ready); else pass_cnt++;
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
        @(negedge clk);
        #1;
        total++; if (req_ready !== 4'b0100) $display("FAIL mid_c1_ready: got %b required 0100", req_ready); else pass_cnt++;
        @(posedge clk);
        #1 req_valid[2] = 1'b0;
        @(negedge clk);
        total++; if (rsp_valid !== 1'b1) $display("FAIL mid_full_valid: got %b required 1", rsp_valid); else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        total++; if (rsp_valid !== 1'b0) $display("FAIL mid_async_drop: got %b required 0", rsp_valid); else pass_cnt++;
        @(negedge clk);
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        total++; if (rsp_valid !== 1'b0) $display("FAIL mid_no_stale0: got %b required 0", rsp_valid); else pass_cnt++;
        set_req(0, C_FLT, 1'b1, D_ONE, D_TWO);
        set_req(3, C_FLT, 1'b1, D_TWO, D_ONE);
        #1;
        total++; if (req_ready !== 4'b0001) $display("FAIL mid_first_grant: got %b required 0001", req_ready); else pass_cnt++;
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        @(negedge clk);
        total++; if (rsp_valid !== 1'b0) $display("FAIL mid_no_stale1: got %b required 0", rsp_valid); else pass_cnt++;
        #1;
        total++; if (req_ready !== 4'b1000) $display("FAIL mid_second_grant: got %b required 1000", req_ready); else pass_cnt++;
        @(posedge clk);
        #1 req_valid[3] = 1'b0;
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_result !== 64'd1)
            $display("FAIL mid_rsp0: valid=%b id=%0d res=%h required valid=1 id=0 res=1", rsp_valid, rsp_id, rsp_result);
        else pass_cnt++;
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_result !== 64'd0)
            $display("FAIL mid_rsp3: valid=%b id=%0d res=%h required valid=1 id=3 res=0", rsp_valid, rsp_id, rsp_result);
        else pass_cnt++;
        @(negedge clk);
        total++; if (rsp_valid !== 1'b0) $display("FAIL mid_drain: got %b required 0", rsp_valid); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single_flt();
        test_nan();
        test_signed_zero_sp();
        test_round_robin();
        test_backpressure();
        test_reset_midflight();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at 200000 required finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fp_compare_arbiter.md
# fp_compare_arbiter

Shares one `FP_Compare` instance among `NUM_REQ` requesters, such as the issue slots of several FPU lanes. Each requester sends an operation with a valid/ready handshake. A round-robin arbiter grants one request per cycle, and a two-stage pipeline registers operands, evaluates the compare and registers the result. Results carry the requester ID and are retired through a valid/ready response port with full backpressure. The block also implements FEQ/FLT/FLE/FMIN/FMAX result and invalid-flag semantics on top of the raw compare flags.

## Interface
- `NUM_REQ`, default 4: number of requesters, minimum 2.
- `ID_W`, default `$clog2(NUM_REQ)`: width of the requester ID.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  per-requester request valid.
- `req_ready`  out  NUM_REQ  per-requester accept; at most one bit high per cycle.
- `req_op`  in  NUM_REQ*3  per-requester opcode, type `fp_cmp_op_e`.
- `req_dp`  in  NUM_REQ  per-requester precision: 1 = double, 0 = single (operand bits [31:0]).
- `req_a`, `req_b`  in  NUM_REQ*64  per-requester operands.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response accept.
- `rsp_id`  out  ID_W  index of the requester that issued the request.
- `rsp_result`  out  64  result value.
- `rsp_invalid`  out  1  IEEE invalid-operation (NV) flag for this response.

## Operation
- **Opcodes** (`fp_cmp_op_e`): FEQ=0, FLT=1, FLE=2, FMIN=3, FMAX=4. Codes 5–7 are illegal.
- **Arbitration**
  - Round-robin pointer `rr_ptr`, reset 0.
  - Grant goes to the first `req_valid` at or after `rr_ptr`, modulo NUM_REQ.
  - `req_ready[g] = grant[g] & s1_free`.
  - On acceptance, `rr_ptr` becomes g+1, wrapping to 0.
  - `rr_ptr` does not move if nothing is accepted.
- **Stage S1 register**: op, dp, a, b, id and `s1_valid`.
  - `FP_Compare` is driven combinationally from the S1 register.
  - `s1_free = !s1_valid | s2_load`.
- **Stage S2 output register**: `rsp_*` fields.
  - `s2_load = s1_valid & (!rsp_valid | rsp_ready)`.
  - `rsp_valid` clears on a `rsp_ready` handshake when there is no `s2_load` in the same cycle.
  - A simultaneous pop and load keeps `rsp_valid` at 1 with the new data.
- **Result rules**
  - FEQ: result = eq; invalid = sNaN in either operand.
  - FLT: result = lt; invalid = unordered.
  - FLE: result = lt|eq; invalid = unordered.
  - FLT, FLE and FEQ results are 0 or 1, zero-extended to 64 bits.
  - FMIN/FMAX when both operands are NaN: result is the canonical NaN.
    - DP: 0x7FF8000000000000.
    - SP: 0x000000007FC00000.
  - FMIN/FMAX when exactly one operand is NaN: result is the other operand.
  - FMIN/FMAX otherwise: select a or b by lt/gt. If eq, FMIN selects the negative-signed operand and FMAX the positive one, so -0 < +0 for min/max only.
  - FMIN/FMAX invalid = sNaN in either operand.
  - SP results have upper 32 bits 0; upper input bits are ignored.
  - Illegal opcode: result 0, invalid 0, response still produced.

## Timing
- **Reset** (asynchronous, immediate; any in-flight S1/S2 entry is discarded):
  - `rsp_valid` = 0, `rsp_id` = 0, `rsp_result` = 0, `rsp_invalid` = 0.
  - `s1_valid` = 0, `rr_ptr` = 0.
  - `req_ready` becomes 0 wherever `req_valid` is 0.
- **Latency**: request accepted on edge k gives `rsp_valid` = 1 after edge k+1. `rsp_ready` is not required.
- **Throughput**: one request per cycle with `rsp_ready` held at 1.
- **Full**: with S1 and S2 both valid and `rsp_ready` = 0, all `req_ready` bits are 0. No request is dropped or duplicated.
- **Stability**
  - `req_ready` may depend combinationally on `req_valid` and `rsp_ready`.
  - Response fields hold stable while `rsp_valid & !rsp_ready`.

## Structure
- Package `fp_cmp_pkg` holds:
  - `fp_cmp_op_e`;
  - the canonical NaN constants `CANON_NAN_DP` and `CANON_NAN_SP`;
  - an S1 payload struct with fields op, dp, a, b, id.
- Sub-module `rr_arbiter #(N)` contains the request vector, advance strobe, one-hot grant, encoded grant and pointer.
- `FP_Compare` is instantiated once.
- Result and flag selection is a local `always_comb`.

## Test plan
- **Single DP FLT**: req0 sends a = 0x3FF0000000000000 (1.0), b = 0x4000000000000000 (2.0) → after 2 edges `rsp_result` = 1, `rsp_invalid` = 0, `rsp_id` = 0.
- **Round-robin fairness**: all 4 requesters hold valid continuously, starting after reset → grants in order 0,1,2,3,0; each `rsp_id` matches its issue order.
- **Backpressure**: hold `rsp_ready` = 0 for 5 cycles with 3 requests pending → exactly 2 accepted and `req_ready` = 0 afterwards. Release `rsp_ready` → the remaining request is accepted and responses arrive in order with data stable while stalled.
- **NaN semantics**
  - FEQ with a = 0x7FF0000000000001 (sNaN), b = 1.0 → result 0, invalid 1.
  - FLE with a = 0x7FF8000000000000 (qNaN) → result 0, invalid 1.
  - FMIN with qNaN and 2.0 → 0x4000000000000000, invalid 0.
  - FMAX with two qNaNs → 0x7FF8000000000000.
- **Signed zero and SP**
  - DP FMIN with +0 and 0x8000000000000000 → 0x8000000000000000.
  - DP FEQ with the same pair → 1.
  - SP FMAX with a = 0x3F800000, b = 0xBF800000 → 0x000000003F800000.
- **Reset mid-flight**: assert `rst_n` = 0 with S1 and S2 both full → `rsp_valid` drops immediately. After release, the first grant goes to requester 0 and no stale response appears.
